// File: rtl/imm_encoder.sv
// RV32I instruction-word encoder with a 2-entry output FIFO, range/opcode checks and a handoff counter.
// Optional macro IMM_ENC_UTYPE_EN adds LUI/AUIPC encoding.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [31:0]      in_imm,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err_range,
  output logic             out_err_opcode,
  output logic [CNT_W-1:0] enc_count
);

  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef IMM_ENC_UTYPE_EN
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`endif

  logic [31:0] enc_instr;
  logic        enc_range;
  logic        enc_opcode;

  logic [31:0] mem_instr [2];
  logic        mem_range [2];
  logic        mem_opcode [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  // Sign-extension test: the upper bits must all match the format's top bit.
  function automatic logic not_sext(input logic [31:0] v, input int lo);
    logic all0, all1;
    all0 = 1'b1;
    all1 = 1'b1;
    for (int i = lo; i < 32; i++) begin
      all0 = all0 & ~v[i];
      all1 = all1 & v[i];
    end
    return ~(all0 | all1);
  endfunction

  always_comb begin
    enc_instr  = 32'h0;
    enc_range  = 1'b0;
    enc_opcode = 1'b0;
    case (in_opcode)
      OP_IALU, OP_LOAD: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_range = not_sext(in_imm, 11);
      end
      OP_STORE: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_range = not_sext(in_imm, 11);
      end
      OP_BRANCH: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_range = not_sext(in_imm, 12) | in_imm[0];
      end
      OP_JAL: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_range = not_sext(in_imm, 20) | in_imm[0];
      end
`ifdef IMM_ENC_UTYPE_EN
      OP_LUI, OP_AUIPC: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_range = |in_imm[11:0];
      end
`endif
      default: enc_opcode = 1'b1;
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_instr[i]  <= 32'h0;
        mem_range[i]  <= 1'b0;
        mem_opcode[i] <= 1'b0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      enc_count <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr]  <= enc_instr;
        mem_range[wr_ptr]  <= enc_range;
        mem_opcode[wr_ptr] <= enc_opcode;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        enc_count <= enc_count + 1'b1;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Head entry drives the outputs; an empty buffer presents all zeros.
  assign out_instr      = out_valid ? mem_instr[rd_ptr]  : 32'h0;
  assign out_err_range  = out_valid ? mem_range[rd_ptr]  : 1'b0;
  assign out_err_opcode = out_valid ? mem_opcode[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed, table-driven bench for imm_encoder plus backpressure and reset sequences.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [31:0] in_imm;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err_range;
  logic        out_err_opcode;
  logic [15:0] enc_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_imm(in_imm), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err_range(out_err_range), .out_err_opcode(out_err_opcode),
    .enc_count(enc_count)
  );

  typedef struct {
    logic [6:0]  op;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] exp_instr;
    logic        exp_rng;
    logic        exp_opc;
  } vec_t;

  vec_t vec [16];
  int   nvec = 0;

  task automatic add(input logic [6:0] op, input logic [31:0] imm, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                     input logic [31:0] ei, input logic er, input logic eo);
    vec[nvec] = '{op, imm, rd, rs1, rs2, f3, ei, er, eo};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [31:0] imm, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3);
    in_opcode = op; in_imm = imm; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3;
  endtask

  logic [31:0] seen [3];
  int          nseen;
  int          cyc;
  logic        c_sent;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(7'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0);

    add(7'b0010011, 32'hFFFFFFFF, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF00093, 1'b0, 1'b0);
    add(7'b0100011, 32'd8,        5'd0, 5'd3, 5'd2, 3'd2, 32'h0021A423, 1'b0, 1'b0);
    add(7'b1100011, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFE000EE3, 1'b0, 1'b0);
    add(7'b1101111, 32'h00000800, 5'd1, 5'd0, 5'd0, 3'd0, 32'h001000EF, 1'b0, 1'b0);
    add(7'b1101111, 32'h00000801, 5'd1, 5'd0, 5'd0, 3'd0, 32'h001000EF, 1'b1, 1'b0);
    add(7'b0010011, 32'h00000800, 5'd1, 5'd0, 5'd0, 3'd0, 32'h80000093, 1'b1, 1'b0);
    add(7'b0110011, 32'h00000000, 5'd1, 5'd2, 5'd3, 3'd0, 32'h00000000, 1'b0, 1'b1);
    add(7'b0000011, 32'hFFFFF800, 5'd2, 5'd1, 5'd0, 3'd2, 32'h8000A103, 1'b0, 1'b0);
    add(7'b0100011, 32'h000007FF, 5'd0, 5'd0, 5'd0, 3'd0, 32'h7E000FA3, 1'b0, 1'b0);
    add(7'b0100011, 32'h00000800, 5'd0, 5'd0, 5'd0, 3'd0, 32'h80000023, 1'b1, 1'b0);
    add(7'b1100011, 32'h00000FFE, 5'd0, 5'd0, 5'd0, 3'd0, 32'h7E000FE3, 1'b0, 1'b0);
    add(7'b1100011, 32'h00001000, 5'd0, 5'd0, 5'd0, 3'd0, 32'h80000063, 1'b1, 1'b0);
`ifdef IMM_ENC_UTYPE_EN
    add(7'b0110111, 32'h12345000, 5'd5, 5'd0, 5'd0, 3'd0, 32'h123452B7, 1'b0, 1'b0);
    add(7'b0010111, 32'h00001001, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00001017, 1'b1, 1'b0);
`else
    add(7'b0110111, 32'h12345000, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0, 1'b1);
    add(7'b0010111, 32'h00001001, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0, 1'b1);
`endif

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_flags", {30'b0, out_err_range, out_err_opcode}, 32'd0);
    chk("rst_enc_count", {16'b0, enc_count}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // One word at a time: not visible before the accepting edge, visible right after it.
    for (int i = 0; i < nvec; i++) begin
      drive(vec[i].op, vec[i].imm, vec[i].rd, vec[i].rs1, vec[i].rs2, vec[i].f3);
      in_valid = 1'b1;
      chk($sformatf("v%0d_pre_valid", i), {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d_instr", i), out_instr, vec[i].exp_instr);
      chk($sformatf("v%0d_err_range", i), {31'b0, out_err_range}, {31'b0, vec[i].exp_rng});
      chk($sformatf("v%0d_err_opcode", i), {31'b0, out_err_opcode}, {31'b0, vec[i].exp_opc});
      @(negedge clk);
    end
    chk("table_enc_count", {16'b0, enc_count}, nvec);

    // Backpressure: three requests, only two fit.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(7'b0010011, 32'd1, 5'd1, 5'd0, 5'd0, 3'd0);
    @(negedge clk);
    drive(7'b0010011, 32'd2, 5'd2, 5'd0, 5'd0, 3'd0);
    @(negedge clk);
    drive(7'b0010011, 32'd3, 5'd3, 5'd0, 5'd0, 3'd0);
    chk("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("bp_still_full", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_instr", out_instr, 32'h00100093);
    out_ready = 1'b1;
    nseen = 0; cyc = 0; c_sent = 1'b0;
    while (nseen < 3 && cyc < 20) begin
      if (out_valid && out_ready) begin
        seen[nseen] = out_instr;
        nseen++;
      end
      if (in_valid && in_ready) c_sent = 1'b1;
      @(negedge clk);
      if (c_sent) in_valid = 1'b0;
      cyc++;
    end
    chk("bp_drain_count", nseen, 32'd3);
    if (nseen == 3) begin
      chk("bp_word0", seen[0], 32'h00100093);
      chk("bp_word1", seen[1], 32'h00200113);
      chk("bp_word2", seen[2], 32'h00300193);
    end
    chk("bp_enc_count", {16'b0, enc_count}, 32'd3);
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Reset while two words are buffered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("mid_full", {31'b0, out_valid, in_ready}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_count", {16'b0, enc_count}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_instr", out_instr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
